reg_scoreboard: RTL and testbench

- Tracks outstanding write-backs to each architectural register and stalls issue of any instruction whose source operands are still in flight.
- Sits between the ID stage (issue side) and the register-file write port (write-back side).
- Watches the same write enable and destination index that the register file consumes, so the two stay in lock-step.
- Replaces static hazard comparison against EXE/MEM destinations with per-register pending counters.

---
 rtl/reg_scoreboard_pkg.sv | 13 +
 rtl/reg_pend_cnt.sv | 43 ++++
 rtl/reg_scoreboard.sv | 58 +++++
 tb/tb_reg_scoreboard.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing, index type and counter saturation helper for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned CNT_W = 2;

  typedef logic [3:0] reg_idx_t;

  function automatic int unsigned cnt_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/reg_pend_cnt.sv
// One per-register pending write-back counter with status flags for the hazard logic.
module reg_pend_cnt #(
  parameter int unsigned CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic is_one,
  output logic is_max,
  output logic underflow
);
  import reg_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] SatVal = CNT_W'(cnt_sat(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign nonzero   = (cnt_q != '0);
  assign is_one    = (cnt_q == CNT_W'(1));
  assign is_max    = (cnt_q == SatVal);
  assign underflow = dec && (cnt_q == '0);

  // Simultaneous inc and dec cancel; a dec at zero holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending write-back scoreboard: stalls issue on in-flight sources or a full
// destination counter, with a same-cycle write-back bypass.
module reg_scoreboard #(
  parameter int unsigned NREGS = reg_scoreboard_pkg::NREGS,
  parameter int unsigned CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_wb_en,
  input  logic [3:0]       issue_dest,
  input  logic [3:0]       issue_src1,
  input  logic [3:0]       issue_src2,
  input  logic             issue_two_src,
  output logic             issue_ready,
  input  logic             wb_en,
  input  logic [3:0]       wb_dest,
  output logic [NREGS-1:0] busy_mask,
  output logic             err
);
  import reg_scoreboard_pkg::*;

  logic [NREGS-1:0] nonzero, is_one, is_max, underflow;
  logic             haz1, haz2, blocked, accept;

  // A single outstanding write landing this cycle is readable by ID (falling-edge RF write).
  assign haz1 = nonzero[issue_src1] && !(is_one[issue_src1] && wb_en && wb_dest == issue_src1);
  assign haz2 = nonzero[issue_src2] && !(is_one[issue_src2] && wb_en && wb_dest == issue_src2);
  assign blocked = issue_wb_en && is_max[issue_dest] && !(wb_en && wb_dest == issue_dest);

  assign issue_ready = !haz1 && !(issue_two_src && haz2) && !blocked;
  assign accept      = issue_valid && issue_ready;
  assign busy_mask   = nonzero;

  for (genvar i = 0; i < NREGS; i++) begin : g_cnt
    reg_pend_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (accept && issue_wb_en && issue_dest == reg_idx_t'(i)),
      .dec       (wb_en && wb_dest == reg_idx_t'(i)),
      .nonzero   (nonzero[i]),
      .is_one    (is_one[i]),
      .is_max    (is_max[i]),
      .underflow (underflow[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (|underflow) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized scoreboard bench for reg_scoreboard against a counter-array reference model.
module tb_reg_scoreboard;

  localparam int NR = 16;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0, issue_wb_en = 1'b0, issue_two_src = 1'b0;
  logic [3:0]    issue_dest = '0, issue_src1 = '0, issue_src2 = '0;
  logic          issue_ready;
  logic          wb_en = 1'b0;
  logic [3:0]    wb_dest = '0;
  logic [NR-1:0] busy_mask;
  logic          err;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_wb_en   (issue_wb_en),
    .issue_dest    (issue_dest),
    .issue_src1    (issue_src1),
    .issue_src2    (issue_src2),
    .issue_two_src (issue_two_src),
    .issue_ready   (issue_ready),
    .wb_en         (wb_en),
    .wb_dest       (wb_dest),
    .busy_mask     (busy_mask),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ready;
    logic [NR-1:0] busy;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  int m_cnt[NR];
  bit m_err;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic bit m_hazard(input int s, input bit wbe, input int wbd);
    return (m_cnt[s] != 0) && !(m_cnt[s] == 1 && wbe && wbd == s);
  endfunction

  // Monitor: outputs are present every cycle; compare against queued expectations.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("issue_ready", 32'(issue_ready), 32'(e.ready));
      check("busy_mask", 32'(busy_mask), 32'(e.busy));
      check("err", 32'(err), 32'(e.err));
    end
  end

  // Called just after a rising edge; drives one cycle and advances to the next edge.
  task automatic cycle(input bit v, input bit iwb, input int d, input int s1, input int s2,
                       input bit two, input bit wbe, input int wbd);
    exp_t e;
    bit   rdy, acc;
    issue_valid   = v;
    issue_wb_en   = iwb;
    issue_dest    = 4'(d);
    issue_src1    = 4'(s1);
    issue_src2    = 4'(s2);
    issue_two_src = two;
    wb_en         = wbe;
    wb_dest       = 4'(wbd);
    rdy = !m_hazard(s1, wbe, wbd) && !(two && m_hazard(s2, wbe, wbd)) &&
          !(iwb && m_cnt[d] == MAXC && !(wbe && wbd == d));
    e.ready = rdy;
    e.err   = m_err;
    for (int i = 0; i < NR; i++) e.busy[i] = (m_cnt[i] != 0);
    exp_q.push_back(e);
    acc = v && rdy;
    for (int i = 0; i < NR; i++) begin
      bit inc, dec;
      inc = acc && iwb && d == i;
      dec = wbe && wbd == i;
      if (dec && m_cnt[i] == 0) m_err = 1'b1;
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    issue_valid = 1'b0;
    wb_en       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy_mask", 32'(busy_mask), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    cycle(1, 1, 3, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 3, 0, 0, 0, 0);
    cycle(1, 0, 0, 3, 0, 0, 1, 3);
    idle();
    repeat (4) cycle(1, 1, 5, 0, 0, 0, 0, 0);
    cycle(1, 1, 5, 0, 0, 0, 1, 5);
    cycle(1, 1, 7, 0, 0, 0, 0, 0);
    cycle(1, 1, 7, 0, 0, 0, 1, 7);
    cycle(0, 0, 0, 0, 0, 0, 1, 9);
    idle();
    cycle(1, 1, 4, 0, 0, 0, 0, 0);
    cycle(1, 1, 6, 6, 6, 1, 0, 0);
    idle();
    async_reset();
    idle();

    for (int n = 0; n < 3000; n++) begin
      int pend[$];
      bit wbe;
      int wbd;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        continue;
      end
      wbe = 1'b0;
      wbd = 0;
      for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) pend.push_back(i);
      if ($urandom_range(0, 1) == 1 && pend.size() != 0) begin
        wbe = 1'b1;
        wbd = pend[$urandom_range(0, pend.size() - 1)];
      end else if ($urandom_range(0, 63) == 0) begin
        wbe = 1'b1;
        wbd = $urandom_range(0, 15);
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1, wbe, wbd);
    end
    idle();
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
